// File: rtl/vga_timing_pkg.sv
// Timing records and standard video modes shared by the VGA timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
        logic         hs_pol;
        logic         vs_pol;
    } video_mode_t;

    localparam video_mode_t MODE_1024X768 = '{
        h: '{active: 1024, fp: 24, sync: 136, bp: 160},
        v: '{active: 768,  fp: 3,  sync: 6,   bp: 29},
        hs_pol: 1'b1,
        vs_pol: 1'b1
    };

    localparam video_mode_t MODE_800X600 = '{
        h: '{active: 800, fp: 40, sync: 128, bp: 88},
        v: '{active: 600, fp: 1,  sync: 4,   bp: 23},
        hs_pol: 1'b1,
        vs_pol: 1'b1
    };

    function automatic int unsigned axis_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_timing_param_if.sv
// Video timing output bundle: positions plus sync/blank/strobe flags.
interface vga_timing_param_if #(
    parameter int unsigned CW = 16
);
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          hblnk;
    logic          vblnk;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with blank/sync flags registered
// from the next count so they always match the count presented with them.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW     = 16,
    parameter int unsigned ACTIVE = 1024,
    parameter int unsigned FP     = 24,
    parameter int unsigned SYNC   = 136,
    parameter int unsigned BP     = 160,
    parameter logic        POL    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          blank,
    output logic          sync,
    output logic          blank_next,
    output logic          zero_next
);
    localparam axis_timing_t TIMING = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
    localparam int unsigned  TOTAL  = axis_total(TIMING);

    generate
        if (64'(TOTAL) > (64'd1 << CW)) begin : g_range_error
            $error("vga_axis_counter: axis total exceeds counter range");
        end
    endgenerate

    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
    // Window bounds carry an extra bit so an end equal to 2^CW does not alias to 0.
    localparam logic [CW:0]   ACT_W    = (CW+1)'(ACTIVE);
    localparam logic [CW:0]   SYNC_BEG = (CW+1)'(ACTIVE + FP);
    localparam logic [CW:0]   SYNC_END = (CW+1)'(ACTIVE + FP + SYNC);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          blank_reg;
    logic          sync_reg;
    logic          sync_next;
    logic [CW:0]   count_ext;

    always_comb begin
        count_next = count_reg;
        if (restart) begin
            count_next = '0;
        end else if (step) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign count_ext  = {1'b0, count_next};
    assign blank_next = (count_ext >= ACT_W);
    assign sync_next  = ((count_ext >= SYNC_BEG) && (count_ext < SYNC_END)) ? POL : ~POL;
    assign zero_next  = (count_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            blank_reg <= 1'b0;
            sync_reg  <= ~POL;
        end else begin
            count_reg <= count_next;
            blank_reg <= blank_next;
            sync_reg  <= sync_next;
        end
    end

    assign count = count_reg;
    assign blank = blank_reg;
    assign sync  = sync_reg;
endmodule

// File: rtl/vga_timing_param.sv
// Parameterised VGA timing generator: horizontal and vertical axis counters
// with fully registered, zero-skew sync/blank/data-enable/start flags.
module vga_timing_param
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = MODE_1024X768.h.active,
    parameter int unsigned H_FP     = MODE_1024X768.h.fp,
    parameter int unsigned H_SYNC   = MODE_1024X768.h.sync,
    parameter int unsigned H_BP     = MODE_1024X768.h.bp,
    parameter int unsigned V_ACTIVE = MODE_1024X768.v.active,
    parameter int unsigned V_FP     = MODE_1024X768.v.fp,
    parameter int unsigned V_SYNC   = MODE_1024X768.v.sync,
    parameter int unsigned V_BP     = MODE_1024X768.v.bp,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned CW       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic                 restart,
    vga_timing_param_if.master   vid
);
    localparam int unsigned   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          h_blank, h_sync, h_blank_next, h_zero_next;
    logic          v_blank, v_sync, v_blank_next, v_zero_next;
    logic          line_end;
    logic          de_reg;
    logic          line_start_reg;
    logic          frame_start_reg;

    // The vertical axis advances only on the enabled edge that wraps the line.
    assign line_end = pix_en && (h_count == H_LAST);

    vga_axis_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
    ) u_h_axis (
        .clk(clk), .rst(rst), .restart(restart), .step(pix_en),
        .count(h_count), .blank(h_blank), .sync(h_sync),
        .blank_next(h_blank_next), .zero_next(h_zero_next)
    );

    vga_axis_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
    ) u_v_axis (
        .clk(clk), .rst(rst), .restart(restart), .step(line_end),
        .count(v_count), .blank(v_blank), .sync(v_sync),
        .blank_next(v_blank_next), .zero_next(v_zero_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            de_reg          <= 1'b1;
            line_start_reg  <= 1'b1;
            frame_start_reg <= 1'b1;
        end else begin
            de_reg          <= !h_blank_next && !v_blank_next;
            line_start_reg  <= h_zero_next;
            frame_start_reg <= h_zero_next && v_zero_next;
        end
    end

    assign vid.hcount      = h_count;
    assign vid.vcount      = v_count;
    assign vid.hsync       = h_sync;
    assign vid.vsync       = v_sync;
    assign vid.hblnk       = h_blank;
    assign vid.vblnk       = v_blank;
    assign vid.de          = de_reg;
    assign vid.line_start  = line_start_reg;
    assign vid.frame_start = frame_start_reg;
endmodule

// File: doc/vga_timing_param.md
VGA_TIMING_PARAM -- requirements
Module: vga_timing_param

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, hsync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 29, vertical back porch
- HS_POL, 1'b1, active hsync level
- VS_POL, 1'b1, active vsync level
- CW, 16, counter width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock
- rst, in, 1, synchronous active-high reset
- pix_en, in, 1, pixel-rate clock enable
- restart, in, 1, synchronous frame restart
- hcount, out, CW, horizontal position
- vcount, out, CW, vertical position
- hsync, out, 1, horizontal sync at HS_POL
- vsync, out, 1, vertical sync at VS_POL
- hblnk, out, 1, horizontal blanking
- vblnk, out, 1, vertical blanking
- de, out, 1, data enable
- line_start, out, 1, position h==0
- frame_start, out, 1, position h==0 and v==0
REQ-003 Single clock domain: clk only. Reset is synchronous and active-high on rst.

Function
REQ-004 Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
REQ-005 Counter advance: only on clk edges with pix_en=1. With pix_en=0, counters and all outputs hold.
REQ-006 hcount range 0..H_TOTAL-1. At H_TOTAL-1 it wraps to 0 and vcount increments.
REQ-007 vcount range 0..V_TOTAL-1. It wraps to 0 when hcount=H_TOTAL-1 and vcount=V_TOTAL-1 coincide.
REQ-008 All outputs are registered. Flags are decoded from the next counter values, so flags always describe the hcount/vcount presented in the same cycle (zero relative latency, no combinational path from inputs to outputs).
REQ-009 Flag decode:
- hblnk=1 iff hcount>=H_ACTIVE
- vblnk=1 iff vcount>=V_ACTIVE
- de = !hblnk && !vblnk
REQ-010 Sync decode:
- hsync=HS_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
- vsync=VS_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL
REQ-011 line_start and frame_start are levels; they stay high for as long as the position holds, so consumers qualify them with pix_en.
REQ-012 restart=1 forces the counters to (0,0) on that clock edge, regardless of pix_en, and outputs take the (0,0) values. restart takes priority over normal advance.
REQ-013 rst takes priority over restart and pix_en.
REQ-014 Counter arithmetic is unsigned CW bits. The implementation shall flag an elaboration error if H_TOTAL or V_TOTAL exceeds 2^CW.

Reset
REQ-015 With rst=1 at a clk edge, the next state is:
- hcount=0, vcount=0
- hblnk=0, vblnk=0, de=1
- hsync=~HS_POL, vsync=~VS_POL
- line_start=1, frame_start=1
REQ-016 Reset mid-frame SHALL abandon the current frame. The first pix_en edge after rst deasserts moves to (1,0).

Structure
REQ-017 Package vga_timing_pkg SHALL hold timing constants for the 1024x768@60 (defaults above) and 800x600@60 modes, plus a timing-record typedef.
REQ-018 One sub-module, vga_axis_counter, SHALL be instantiated twice (horizontal, vertical). Each instance has:
- count, wrap, blank and sync decode
- a step input and a restart input
- parameters ACTIVE/FP/SYNC/BP/POL

Verification
REQ-019 Reset: assert rst for 3 cycles with pix_en=1 -> hcount=0, vcount=0, de=1, hsync=0, vsync=0, frame_start=1.
REQ-020 Line wrap: run from reset with pix_en=1 -> after 1343 enabled edges hcount=1343 and hblnk=1. The next edge gives hcount=0, vcount=1, line_start=1.
REQ-021 Sync windows: over one full frame -> hsync=1 exactly for hcount 1048..1183, and vsync=1 exactly for vcount 771..776. The frame is exactly 1344*806=1083264 enabled cycles between frame_start assertions.
REQ-022 Stall: pix_en toggling 1,0,0,1 at hcount=10 -> hcount sequence 11,11,11,12 with outputs frozen during the stall.
REQ-023 Restart mid-frame: at (500,300) with pix_en=0, pulse restart -> next cycle (0,0), frame_start=1, de=1. Then rst and restart together -> reset values.
REQ-024 Polarity: instantiate with HS_POL=0, VS_POL=0 -> hsync=0 only for hcount 1048..1183 and vsync idles at 1.
